// File: rtl/cnt_share_arbiter_if.sv
// ============================================================================
// Module   : cnt_share_arbiter_if
// Function : Request/grant/counter bundle between clients and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnt_share_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]  req;
  logic             clr;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic [WIDTH-1:0] cnt;
  logic             wrap;

  modport master (
    output req, clr,
    input  gnt, value, valid, cnt, wrap
  );

  modport slave (
    input  req, clr,
    output gnt, value, valid, cnt, wrap
  );
endinterface

`default_nettype wire

// File: rtl/cnt_share_arbiter.sv
// ============================================================================
// Module   : cnt_share_arbiter
// Function : Round-robin arbiter serialising increments of one shared counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  wire                  clk,
  input  wire                  rst,
  cnt_share_arbiter_if.slave   bus
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTRW:0] C_NREQ = (PTRW+1)'(NREQ);

  logic [NREQ-1:0]  gnt_q,   gnt_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             wrap_q,  wrap_d;
  logic [PTRW-1:0]  ptr_q,   ptr_d;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [PTRW-1:0]  win;
  logic [PTRW:0]    cand;
  logic [PTRW:0]    win_inc;
  logic [PTRW-1:0]  ptr_next;
  logic             cnt_max;
  logic [WIDTH-1:0] cnt_inc;

  // Last cycle's winner is masked so a held request cannot win back-to-back.
  assign elig = bus.req & ~gnt_q;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PTRW+1)'(i);
      if (cand >= C_NREQ) begin
        cand = cand - C_NREQ;
      end
      if (!found && elig[cand[PTRW-1:0]]) begin
        found = 1'b1;
        win   = cand[PTRW-1:0];
      end
    end
  end

  always_comb begin
    win_inc  = {1'b0, win} + (PTRW+1)'(1);
    ptr_next = (win_inc == C_NREQ) ? '0 : win_inc[PTRW-1:0];
  end

  assign cnt_max = (cnt_q == {WIDTH{1'b1}});
  assign cnt_inc = cnt_max ? '0 : cnt_q + WIDTH'(1);

  always_comb begin
    gnt_d   = '0;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    value_d = value_q;
    ptr_d   = ptr_q;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (found) begin
      gnt_d[win] = 1'b1;
      valid_d    = 1'b1;
      cnt_d      = cnt_inc;
      value_d    = cnt_inc;
      wrap_d     = cnt_max;
      ptr_d      = ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      value_q <= '0;
      ptr_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.cnt   = cnt_q;
  assign bus.wrap  = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_cnt_share_arbiter.sv
// ============================================================================
// Module   : tb_cnt_share_arbiter
// Function : Vector table, directed corner sequences and random vs. model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_share_arbiter;

  localparam int W = 4;
  localparam int N = 4;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    logic         rst;
    logic         clr;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] value;
    logic         valid;
    logic [W-1:0] cnt;
    logic         wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  cnt_share_arbiter_if #(.WIDTH(W), .NREQ(N)) ifc ();

  cnt_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference: counter as an integer modulo 2^W, pointer as an integer modulo N.
  int m_cnt = 0, m_ptr = 0, m_gnt = -1, m_value = 0, m_valid = 0, m_wrap = 0;

  task automatic model_step(input logic r, input logic c, input logic [N-1:0] q);
    int w;
    w = -1;
    if (r) begin
      m_cnt = 0; m_ptr = 0; m_gnt = -1; m_value = 0; m_valid = 0; m_wrap = 0;
    end else if (c) begin
      m_cnt = 0; m_gnt = -1; m_valid = 0; m_wrap = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && q[j] && j != m_gnt) w = j;
      end
      if (w >= 0) begin
        m_wrap  = (m_cnt == MAXV) ? 1 : 0;
        m_cnt   = (m_cnt + 1) % (MAXV + 1);
        m_value = m_cnt;
        m_ptr   = (w + 1) % N;
        m_gnt   = w;
        m_valid = 1;
      end else begin
        m_gnt = -1; m_valid = 0; m_wrap = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [N-1:0] q);
    rst     = r;
    ifc.clr = c;
    ifc.req = q;
    @(posedge clk);
    #1;
    model_step(r, c, q);
  endtask

  task automatic check(input string tag, input logic [N-1:0] g, input logic [W-1:0] v,
                       input logic vl, input logic [W-1:0] c, input logic wr);
    checks++;
    if ({ifc.gnt, ifc.value, ifc.valid, ifc.cnt, ifc.wrap} !== {g, v, vl, c, wr}) begin
      failures++;
      $display("FAIL %s: got gnt=%b value=%0d valid=%b cnt=%0d wrap=%b, expected gnt=%b value=%0d valid=%b cnt=%0d wrap=%b",
               tag, ifc.gnt, ifc.value, ifc.valid, ifc.cnt, ifc.wrap, g, v, vl, c, wr);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] g;
    g = '0;
    if (m_gnt >= 0) g[m_gnt] = 1'b1;
    check(tag, g, W'(m_value), m_valid[0], W'(m_cnt), m_wrap[0]);
  endtask

  vec_t tbl[$];

  function automatic void add(logic r, logic c, logic [N-1:0] q, logic [N-1:0] g,
                              int v, logic vl, int cn, logic wr);
    vec_t e;
    e.rst = r; e.clr = c; e.req = q; e.gnt = g;
    e.value = W'(v); e.valid = vl; e.cnt = W'(cn); e.wrap = wr;
    tbl.push_back(e);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] q;
    ifc.req = '0;
    ifc.clr = 1'b0;

    // reset with everything asserted, then first grant
    add(1, 1, 4'b1111, 4'b0000, 0, 0, 0, 0);
    add(1, 1, 4'b1111, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0001, 4'b0001, 1, 1, 1, 0);
    // round robin from pointer 0
    add(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 4'b1111, 4'(1 << (i % 4)), i + 1, 1, i + 1, 0);
    add(0, 0, 4'b0000, 4'b0000, 8, 0, 8, 0);
    // single held requester: every other cycle
    add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      add(0, 0, 4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, i / 2 + 1, (i % 2 == 0), i / 2 + 1, 0);
    // clear collides with a request
    add(0, 0, 4'b0001, 4'b0001, 4, 1, 4, 0);
    add(0, 0, 4'b0010, 4'b0010, 5, 1, 5, 0);
    add(0, 1, 4'b0010, 4'b0000, 5, 0, 0, 0);
    add(0, 0, 4'b0010, 4'b0010, 1, 1, 1, 0);
    add(0, 0, 4'b0000, 4'b0000, 1, 0, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].req);
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].value, tbl[i].valid, tbl[i].cnt, tbl[i].wrap);
    end

    // wrap: two alternating requesters drive the count to all-ones and past it
    step(1, 0, 4'b0000);
    for (int i = 0; i < 14; i++) step(0, 0, 4'b0011);
    check("wrap_14", 4'b0010, 4'd14, 1'b1, 4'd14, 1'b0);
    step(0, 0, 4'b0011);
    check("wrap_15", 4'b0001, 4'd15, 1'b1, 4'd15, 1'b0);
    step(0, 0, 4'b0011);
    check("wrap_0", 4'b0010, 4'd0, 1'b1, 4'd0, 1'b1);
    step(0, 0, 4'b0000);
    check("wrap_idle", 4'b0000, 4'd0, 1'b0, 4'd0, 1'b0);

    // withdrawn request never granted
    step(1, 0, 4'b0000);
    step(0, 0, 4'b0001);
    check("wd_first", 4'b0001, 4'd1, 1'b1, 4'd1, 1'b0);
    step(0, 0, 4'b1010);
    check("wd_lose", 4'b0010, 4'd2, 1'b1, 4'd2, 1'b0);
    step(0, 0, 4'b0000);
    check("wd_drop", 4'b0000, 4'd2, 1'b0, 4'd2, 1'b0);

    // reset in the middle of a grant stream
    step(0, 0, 4'b1111);
    check("mid_g0", 4'b0100, 4'd3, 1'b1, 4'd3, 1'b0);
    step(0, 0, 4'b1111);
    step(0, 0, 4'b1111);
    check("mid_g2", 4'b0001, 4'd5, 1'b1, 4'd5, 1'b0);
    step(1, 0, 4'b1111);
    check("mid_rst", 4'b0000, 4'd0, 1'b0, 4'd0, 1'b0);
    step(0, 0, 4'b1111);
    check("mid_after", 4'b0001, 4'd1, 1'b1, 4'd1, 1'b0);

    // random traffic against the reference model
    step(1, 0, 4'b0000);
    check_model("rnd_rst");
    q = '0;
    for (int i = 0; i < 600; i++) begin
      logic r, c;
      logic [N-1:0] nw;
      r  = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 11) == 0);
      nw = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 4) == 0) q = nw;
      else q = (q & ~ifc.gnt) | (nw & N'($urandom_range(0, (1 << N) - 1)));
      step(r, c, q);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
